// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: occupancy state encoding and the
// default payload layout (instruction word concatenated with word-aligned PC).
package pipe_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 30;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_stage_slot.sv
// One payload slot of a pipeline stage: async reset, load enable and a
// synchronous clear that wins over load (used for flush / drain to bubble).
module pipe_stage_slot #(
  parameter int                DATA_W  = 62,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] data_q;

  // clear beats load so a flush can never leave stale payload behind
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         data_q <= RST_VAL;
    else if (clr_i)  data_q <= RST_VAL;
    else if (load_i) data_q <= d_i;
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, 2-entry skid
// buffer and synchronous flush. out_data comes straight from the main slot;
// the skid slot only holds the entry accepted while the consumer stalled.
// in_ready is registered so out_ready never reaches in_ready combinationally.
// Optional feature macro: PIPE_STAGE_STALL_CNT_EN adds a saturating
// stall-cycle counter on port stall_cnt.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W  = INSTR_W + PC_W,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  parameter int                CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("pipe_stage_reg: CNT_W must be at least 1");
  end

  pipe_state_e       state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              in_xfer, out_xfer;
  logic              main_ld, main_clr, skid_ld, skid_clr;
  logic [DATA_W-1:0] main_d, skid_q;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = in_ready_q;
  assign in_xfer   = in_valid & in_ready_q;
  assign out_xfer  = out_valid & out_ready;

  // next occupancy and slot controls; flush overrides every other transition
  always_comb begin
    state_d  = state_q;
    main_ld  = 1'b0;
    main_clr = 1'b0;
    main_d   = in_data;
    skid_ld  = 1'b0;
    skid_clr = 1'b0;
    if (flush) begin
      state_d  = EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d = ONE;
            main_ld = 1'b1;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_ld = 1'b1;
          end else if (in_xfer) begin
            state_d = TWO;
            skid_ld = 1'b1;
          end else if (out_xfer) begin
            state_d  = EMPTY;
            main_clr = 1'b1;
          end
        end
        TWO: begin
          // skid entry moves up; in_ready is low so no new input can arrive
          if (out_xfer) begin
            state_d  = ONE;
            main_d   = skid_q;
            main_ld  = 1'b1;
            skid_clr = 1'b1;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
    in_ready_d = (state_d != TWO);
  end

  // occupancy state and registered in_ready; in_ready stays low in reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  pipe_stage_slot #(.DATA_W(DATA_W), .RST_VAL(RST_VAL)) u_main (
    .clk    (clk),
    .rst    (rst),
    .load_i (main_ld),
    .clr_i  (main_clr),
    .d_i    (main_d),
    .q_o    (out_data)
  );

  pipe_stage_slot #(.DATA_W(DATA_W), .RST_VAL(RST_VAL)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .load_i (skid_ld),
    .clr_i  (skid_clr),
    .d_i    (in_data),
    .q_o    (skid_q)
  );

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // count cycles where valid data waits on the consumer; sticks at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                               stall_cnt_q <= '0;
    else if (out_valid && !out_ready && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: reset checks, a directed vector
// table (streaming, back-pressure, flush cases), randomized traffic against a
// queue-based reference model, and async reset in the middle of a cycle.
// Stall-counter checks are compiled in when PIPE_STAGE_STALL_CNT_EN is defined.
module tb_pipe_stage_reg;

  localparam int DW = 62;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, flush, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [15:0]   stall_cnt;
  logic          sat_in_ready, sat_out_valid;
  logic [DW-1:0] sat_out_data;
  logic [1:0]    sat_cnt;
`endif

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

`ifdef PIPE_STAGE_STALL_CNT_EN
  pipe_stage_reg #(.DATA_W(DW), .CNT_W(2)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (sat_in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (sat_out_valid),
    .out_ready (out_ready),
    .out_data  (sat_out_data),
    .stall_cnt (sat_cnt)
  );
`endif

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [DW-1:0] d, input logic fl, input logic ordy);
    in_valid  = iv;
    in_data   = d;
    flush     = fl;
    out_ready = ordy;
  endtask

  // advance one clock and settle just after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (3) cyc();
    chk("reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset out_data",  {2'd0, out_data},   64'd0);
    chk("reset in_ready",  {63'd0, in_ready},  64'd0);
`ifdef PIPE_STAGE_STALL_CNT_EN
    chk("reset stall_cnt", {48'd0, stall_cnt}, 64'd0);
`endif
    rst = 1'b0;
    cyc();
    chk("in_ready after release", {63'd0, in_ready}, 64'd1);
    chk("out_valid after release", {63'd0, out_valid}, 64'd0);
  endtask

  // ---------------- reference model: FIFO of at most two entries ----------
  logic [DW-1:0] mq[$];
  bit            m_rdy;
  int unsigned   m_cnt;

  task automatic model_reset();
    mq.delete();
    m_rdy = 1'b1;   // value after the first post-reset edge
    m_cnt = 0;
  endtask

  // apply the current inputs at the coming clock edge
  task automatic model_edge();
    bit ix, ox;
    ix = in_valid && m_rdy;
    ox = (mq.size() > 0) && out_ready;
    if ((mq.size() > 0) && !out_ready && (m_cnt < 65535)) m_cnt++;
    if (ox) void'(mq.pop_front());
    if (flush) mq.delete();
    else if (ix) mq.push_back(in_data);
    m_rdy = (mq.size() < 2);
  endtask

  // ---------------- directed vector table --------------------------------
  typedef struct {
    string         nm;
    logic          iv;
    logic [DW-1:0] d;
    logic          fl;
    logic          ordy;
    logic          ov;
    logic [DW-1:0] od;
    logic          ir;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input string nm, input logic iv, input logic [DW-1:0] d,
                              input logic fl, input logic ordy,
                              input logic ov, input logic [DW-1:0] od, input logic ir);
    vec_t v;
    v.nm = nm; v.iv = iv; v.d = d; v.fl = fl; v.ordy = ordy;
    v.ov = ov; v.od = od; v.ir = ir;
    tbl.push_back(v);
  endfunction

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);

    // streaming at full rate, one cycle after acceptance
    add("stream 11", 1, 'h11, 0, 1, 1, 'h11, 1);
    add("stream 12", 1, 'h12, 0, 1, 1, 'h12, 1);
    add("stream 13", 1, 'h13, 0, 1, 1, 'h13, 1);
    add("stream 14", 1, 'h14, 0, 1, 1, 'h14, 1);
    add("stream 15", 1, 'h15, 0, 1, 1, 'h15, 1);
    add("stream drain", 0, 'h0, 0, 1, 0, 'h0, 1);
    // back-pressure: A1 out, then stall while A2/A3 offered
    add("bp A1",      1, 'hA1, 0, 1, 1, 'hA1, 1);
    add("bp A2 skid", 1, 'hA2, 0, 0, 1, 'hA1, 0);
    add("bp A3 held", 1, 'hA3, 0, 0, 1, 'hA1, 0);
    add("bp A3 held2",1, 'hA3, 0, 0, 1, 'hA1, 0);
    add("bp rel A2",  1, 'hA3, 0, 1, 1, 'hA2, 1);
    add("bp A3",      1, 'hA3, 0, 1, 1, 'hA3, 1);
    add("bp A4",      1, 'hA4, 0, 1, 1, 'hA4, 1);
    add("bp drain",   0, 'h0,  0, 1, 0, 'h0,  1);
    // flush while TWO with a concurrent input
    add("fl B1",      1, 'hB1, 0, 0, 1, 'hB1, 1);
    add("fl B2",      1, 'hB2, 0, 0, 1, 'hB1, 0);
    add("fl two FF",  1, 'hFF, 1, 0, 0, 'h0,  1);
    add("fl after",   0, 'h0,  0, 1, 0, 'h0,  1);
    // flush with simultaneous output transfer
    add("fo 42",      1, 'h42, 0, 1, 1, 'h42, 1);
    add("fo flush",   0, 'h0,  1, 1, 0, 'h0,  1);
    add("fo idle",    0, 'h0,  0, 1, 0, 'h0,  1);
    // flush from EMPTY discards the input taken that cycle
    add("fe 77",      1, 'h77, 1, 1, 0, 'h0,  1);
    add("fe idle",    0, 'h0,  0, 1, 0, 'h0,  1);

    do_reset();
    foreach (tbl[i]) begin
      drive(tbl[i].iv, tbl[i].d, tbl[i].fl, tbl[i].ordy);
      cyc();
      chk({tbl[i].nm, " out_valid"}, {63'd0, out_valid}, {63'd0, tbl[i].ov});
      chk({tbl[i].nm, " out_data"},  {2'd0, out_data},   {2'd0, tbl[i].od});
      chk({tbl[i].nm, " in_ready"},  {63'd0, in_ready},  {63'd0, tbl[i].ir});
    end

`ifdef PIPE_STAGE_STALL_CNT_EN
    // stall counter: 5 + 3 stall cycles, flush does not clear, CNT_W=2 saturates
    do_reset();
    drive(1'b1, 'h5, 1'b0, 1'b0);
    cyc();                      // entry loaded; no stall counted yet
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (5) cyc();
    chk("stall_cnt 5", {48'd0, stall_cnt}, 64'd5);
    chk("sat after 5", {62'd0, sat_cnt}, 64'd3);
    drive(1'b0, '0, 1'b0, 1'b1);
    cyc();                      // consumed, not a stall cycle
    drive(1'b1, 'h6, 1'b0, 1'b0);
    cyc();
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (3) cyc();
    chk("stall_cnt 8", {48'd0, stall_cnt}, 64'd8);
    drive(1'b0, '0, 1'b1, 1'b1);
    cyc();
    drive(1'b0, '0, 1'b0, 1'b1);
    cyc();
    chk("stall_cnt kept after flush", {48'd0, stall_cnt}, 64'd8);
    chk("sat held", {62'd0, sat_cnt}, 64'd3);
`endif

    // randomized traffic against the reference model
    do_reset();
    model_reset();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), DW'({$urandom(), $urandom()}),
            1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 2) != 0));
      model_edge();
      cyc();
      chk("rnd out_valid", {63'd0, out_valid}, {63'd0, (mq.size() > 0)});
      chk("rnd out_data",  {2'd0, out_data},   {2'd0, (mq.size() > 0) ? mq[0] : {DW{1'b0}}});
      chk("rnd in_ready",  {63'd0, in_ready},  {63'd0, m_rdy});
`ifdef PIPE_STAGE_STALL_CNT_EN
      chk("rnd stall_cnt", {48'd0, stall_cnt}, 64'(m_cnt));
`endif
    end

    // async reset mid-cycle drops held data without a clock edge
    drive(1'b1, 'h5A, 1'b0, 1'b0);
    cyc();
    drive(1'b0, '0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("async rst out_valid", {63'd0, out_valid}, 64'd0);
    chk("async rst out_data",  {2'd0, out_data},   64'd0);
    chk("async rst in_ready",  {63'd0, in_ready},  64'd0);
    #10 rst = 1'b0;
    cyc();
    chk("post async in_ready", {63'd0, in_ready}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, a 2-entry skid buffer and synchronous flush. It generalises the fixed IF/ID latch to any payload width. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Back-pressure, hazard stalls and branch flushes are handled uniformly, and no data is lost or duplicated.

## Interface
Parameters:
- DATA_W, 62: payload width in bits (default is instr[31:0] concatenated with PC[29:0]).
- RST_VAL, {DATA_W{1'b0}}: payload value on reset and flush (bubble/NOP).
- CNT_W, 16: stall-counter width; used only when PIPE_STAGE_STALL_CNT_EN is defined.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream presents in_data.
- in_ready  out  1  stage can accept; driven from a register.
- in_data  in  DATA_W  upstream payload.
- flush  in  1  synchronous kill of all held entries (branch taken / exception).
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts; low means stall.
- out_data  out  DATA_W  payload to the next stage, driven from the main register.
- stall_cnt  out  CNT_W  stall-cycle count; present only with PIPE_STAGE_STALL_CNT_EN.

## Operation
- Storage: main register (drives out_data), skid register, and a 2-bit state EMPTY/ONE/TWO.
- Input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready.
- out_valid = (state != EMPTY). in_ready is registered: next in_ready = (next state != TWO).
- Transitions when flush = 0:
  - EMPTY: input transfer → ONE, main<=in_data. Otherwise stay.
  - ONE, input and output transfer: stay ONE, main<=in_data.
  - ONE, input transfer only: → TWO, skid<=in_data.
  - ONE, output transfer only: → EMPTY, main<=RST_VAL.
  - ONE, neither: hold.
  - TWO: output transfer → ONE, main<=skid, skid<=RST_VAL. Otherwise hold. in_ready=0, so input is ignored.
- Flush has highest priority:
  - Next state is EMPTY; main<=RST_VAL and skid<=RST_VAL; next in_ready=1.
  - An input transfer in the same cycle is accepted by upstream and discarded.
  - An output transfer in the same cycle completes normally.
- Ordering is strictly FIFO. The skid entry is never overtaken.
- Held payload is never changed by in_data while out_ready=0.

## Timing
- Reset (async assert): state=EMPTY, out_valid=0, out_data=RST_VAL, skid=RST_VAL, in_ready=0, stall_cnt=0.
- in_ready rises on the first posedge after rst deasserts.
- Latency: in_data accepted at edge N appears on out_data after edge N, with out_valid=1 from then on.
- Throughput: 1 transfer/cycle at full rate. No combinational path from out_ready to in_ready.
- After out_ready drops, up to 2 entries are absorbed. in_ready falls one cycle after entering TWO is decided, which is the registered edge.
- Reset asserted mid-transfer: all state is lost immediately and outputs take their reset values asynchronously.

## Configuration
- PIPE_STAGE_STALL_CNT_EN defined:
  - Adds output stall_cnt.
  - Increments on every cycle with out_valid & !out_ready.
  - Saturates at all-ones.
  - Cleared only by rst, not by flush.
- Undefined: the port and counter are absent and behaviour is otherwise identical.

## Structure
- Shared package pipe_pkg:
  - state typedef (EMPTY=2'd0, ONE=2'd1, TWO=2'd2).
  - NOP_INSTR constant 32'h0000_0000.
  - Default widths INSTR_W=32 and PC_W=30.
- Sub-module pipe_stage_slot: DATA_W-wide register with async reset, load enable and synchronous clear-to-RST_VAL. It is instantiated twice, once for main and once for skid.

## Test plan
- Reset: hold rst=1 for 3 cycles → out_valid=0, out_data=0, in_ready=0. One posedge after release → in_ready=1.
- Streaming: out_ready=1 and inputs 0x11..0x15 back-to-back → out_data 0x11..0x15 on consecutive cycles, each one cycle after acceptance, no gaps.
- Back-pressure:
  - Stimulus: out_ready=0 after 0xA1 is output, then send 0xA2 and 0xA3.
  - Expected while stalled: state TWO, in_ready=0, out_data holds 0xA1.
  - Expected after release: 0xA1, 0xA2, 0xA3 delivered in order; 0xA4 is not accepted until in_ready=1.
- Flush in TWO: flush=1 with in_valid=1 and data 0xFF → next cycle out_valid=0, out_data=RST_VAL, in_ready=1. 0xFF never appears at the output.
- Flush with simultaneous output transfer: in ONE with 0x42 and out_ready=1, assert flush → 0x42 is consumed once and the stage is then EMPTY.
- Stall counter (macro defined): stall 5 cycles, then stall 3 more → stall_cnt=8. An intervening flush does not clear it. With CNT_W=2, 6 stall cycles saturate the counter at 3.
